// File: rtl/fcvt_share_ctrl.sv
// rtl/fcvt_share_ctrl.sv - round-robin sequencer sharing one float->int converter among N_REQ requesters
// Optional macro FCVT_FFLAGS_ACC_EN adds sticky accrued NV/NX flags with a clear input.
module fcvt_share_ctrl #(
  parameter int N_REQ   = 2,
  parameter int F_WIDTH = 32,
  parameter int I_WIDTH = 32,
  parameter int ID_W    = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ-1:0]         req_op,
  input  logic [N_REQ*F_WIDTH-1:0] req_data,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [ID_W-1:0]          rsp_id,
  output logic [I_WIDTH-1:0]       rsp_data,
  output logic                     rsp_invalid,
  output logic                     rsp_inexact,
  output logic [F_WIDTH-1:0]       cvt_in,
  output logic                     cvt_op,
  input  logic [I_WIDTH-1:0]       cvt_out,
  input  logic                     cvt_invalid,
  input  logic                     cvt_inexact,
`ifdef FCVT_FFLAGS_ACC_EN
  input  logic                     fflags_clr,
  output logic                     fflags_nv,
  output logic                     fflags_nx,
`endif
  output logic                     busy
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] cur_id;
  logic [ID_W-1:0] grant_idx;
  logic            grant_found;
  logic            rsp_hs;

  // Search starts just after the last winner so the winner drops to lowest priority.
  always_comb begin
    logic [ID_W-1:0] idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
      if (!grant_found && req_valid[idx]) begin
        grant_found = 1'b1;
        grant_idx   = idx;
      end
    end
  end

  assign req_ready = (state == S_IDLE && grant_found) ? (N_REQ'(1) << grant_idx) : '0;
  assign rsp_valid = (state == S_RESP);
  assign busy      = (state != S_IDLE);
  assign rsp_hs    = (state == S_RESP) && rsp_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= ID_W'(N_REQ - 1);
      cur_id      <= '0;
      cvt_in      <= '0;
      cvt_op      <= 1'b0;
      rsp_id      <= '0;
      rsp_data    <= '0;
      rsp_invalid <= 1'b0;
      rsp_inexact <= 1'b0;
`ifdef FCVT_FFLAGS_ACC_EN
      fflags_nv   <= 1'b0;
      fflags_nx   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (grant_found) begin
            cvt_in <= req_data[int'(grant_idx)*F_WIDTH +: F_WIDTH];
            cvt_op <= req_op[grant_idx];
            cur_id <= grant_idx;
            rr_ptr <= grant_idx;
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          rsp_data    <= cvt_out;
          rsp_invalid <= cvt_invalid;
          rsp_inexact <= cvt_inexact;
          rsp_id      <= cur_id;
          state       <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
`ifdef FCVT_FFLAGS_ACC_EN
      // A handshake in the same cycle as a clear still leaves its flags set.
      fflags_nv <= (fflags_clr ? 1'b0 : fflags_nv) | (rsp_hs & rsp_invalid);
      fflags_nx <= (fflags_clr ? 1'b0 : fflags_nx) | (rsp_hs & rsp_inexact);
`endif
    end
  end

endmodule
